// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-scan feature map, using a half-row buffer.
// Optional: define MAXPOOL_RELU_EN to clamp negative pooled results to zero (fused ReLU, no extra latency).
module maxpool2x2_stream #(
   parameter int DATA_W = 8,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic                     clk,
   input  logic                     RSTn,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     frame_done
);

   localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
   localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int BW = (IMG_W > 4) ? $clog2(IMG_W / 2) : 1;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [DATA_W-1:0] finalize(input logic signed [DATA_W-1:0] v);
`ifdef MAXPOOL_RELU_EN
      return v[DATA_W-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   logic [CW-1:0]              col_q, col_d;
   logic [RW-1:0]              row_q, row_d;
   logic signed [DATA_W-1:0]   hold_q, hold_d;
   logic signed [DATA_W-1:0]   out_data_q, out_data_d;
   logic                       out_valid_q, out_valid_d;
   logic                       last_q, last_d;
   logic                       frame_done_q, frame_done_d;

   logic signed [DATA_W-1:0]   line_q [IMG_W/2];
   logic [BW-1:0]              line_idx;
   logic                       line_we;
   logic signed [DATA_W-1:0]   line_wdata;
   logic signed [DATA_W-1:0]   line_rdata;

   logic in_fire, out_fire, col_last, row_last;

   assign in_ready   = !out_valid_q || out_ready;
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid_q && out_ready;
   assign col_last   = (col_q == CW'(IMG_W - 1));
   assign row_last   = (row_q == RW'(IMG_H - 1));
   assign line_idx   = BW'(col_q >> 1);
   assign line_rdata = line_q[line_idx];

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign frame_done = frame_done_q;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      col_d        = col_q;
      row_d        = row_q;
      hold_d       = hold_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      last_d       = last_q;
      line_we      = 1'b0;
      line_wdata   = '0;
      frame_done_d = out_fire && last_q;

      if (out_fire) out_valid_d = 1'b0;

      if (in_fire) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_last ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end

         // Even row builds the horizontal pair max; odd row folds it with the vertical pair.
         unique case ({row_q[0], col_q[0]})
            2'b00: hold_d = in_data;
            2'b01: begin
               line_we    = 1'b1;
               line_wdata = smax(hold_q, in_data);
            end
            2'b10: hold_d = smax(line_rdata, in_data);
            2'b11: begin
               out_data_d  = finalize(smax(hold_q, in_data));
               out_valid_d = 1'b1;
               last_d      = row_last && col_last;
            end
            default: ;
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge RSTn) begin
      if (!RSTn) begin
         col_q        <= '0;
         row_q        <= '0;
         hold_q       <= '0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         last_q       <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         hold_q       <= hold_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         last_q       <= last_d;
         frame_done_q <= frame_done_d;
      end
   end

   // NOTE: the line buffer has no reset; every entry is written on an even row before it is read.
   always_ff @(posedge clk) begin
      if (line_we) line_q[line_idx] <= line_wdata;
   end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed and model-checked bench for maxpool2x2_stream: a 4x2 instance for directed frames,
// a 28x28 instance for two back-to-back random frames with input gaps and output back-pressure.
module tb_maxpool2x2_stream;

   logic clk = 1'b0;
   logic RSTn;
   always #5 clk = ~clk;

   // small 4x2 instance
   logic              s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_frame_done;
   logic signed [7:0] s_in_data, s_out_data;

   // full 28x28 instance
   logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_frame_done;
   logic signed [7:0] b_in_data, b_out_data;

   maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) u_small (
      .clk(clk), .RSTn(RSTn),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .frame_done(s_frame_done)
   );

   maxpool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28)) u_big (
      .clk(clk), .RSTn(RSTn),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .frame_done(b_frame_done)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [7:0] relu8(input logic signed [7:0] v);
`ifdef MAXPOOL_RELU_EN
      return (v < 0) ? 8'sd0 : v;
`else
      return v;
`endif
   endfunction

   // Small-instance driver state
   logic signed [7:0] sm_pix [8];
   logic signed [7:0] s_got [$];
   int                sent, s_fd;
   logic              s_en, s_ordy;

   task automatic small_cycle();
      @(posedge clk);
      #1;
      s_in_valid  = s_en && (sent < 8);
      s_in_data   = s_in_valid ? sm_pix[sent] : 8'sd0;
      s_out_ready = s_ordy;
      @(negedge clk);
      if (s_in_valid && s_in_ready) sent++;
      if (s_out_valid && s_out_ready) s_got.push_back(s_out_data);
      if (s_frame_done) s_fd++;
   endtask

   task automatic run_small(input string tag, input logic signed [7:0] e0,
                            input logic signed [7:0] e1);
      sent = 0; s_fd = 0; s_got.delete();
      s_en = 1'b1; s_ordy = 1'b1;
      repeat (14) small_cycle();
      s_en = 1'b0;
      check({tag, "_count"}, s_got.size(), 2);
      check({tag, "_out0"}, s_got[0], e0);
      check({tag, "_out1"}, s_got[1], e1);
      check({tag, "_frame_done"}, s_fd, 1);
   endtask

   // Big-instance model data
   logic signed [7:0] pix_b [1568];
   logic signed [7:0] exp_b [392];
   int bsent, bgot, bfd, bcyc;

   initial begin
      RSTn = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      s_en = 1'b0; s_ordy = 1'b1; sent = 0; s_fd = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", s_out_valid, 0);
      check("rst_in_ready", s_in_ready, 1);
      check("rst_out_data", s_out_data, 0);
      check("rst_frame_done", s_frame_done, 0);
      @(negedge clk);
      RSTn = 1'b1;

      // Basic frame: windows {1,5,4,0} and {2,3,7,6}
      sm_pix = '{8'sd1, 8'sd5, 8'sd2, 8'sd3, 8'sd4, 8'sd0, 8'sd7, 8'sd6};
      run_small("basic", relu8(8'sd5), relu8(8'sd7));

      // All-negative frame: -3 and -1, or 0 and 0 with ReLU
      sm_pix = '{-8'sd3, -8'sd8, -8'sd1, -8'sd2, -8'sd5, -8'sd4, -8'sd9, -8'sd7};
      run_small("negative", relu8(-8'sd3), relu8(-8'sd1));

      // Mixed-sign window catches an unsigned compare
      sm_pix = '{8'sd127, -8'sd128, 8'sd0, 8'sd0, -8'sd1, 8'sd0, 8'sd0, 8'sd0};
      run_small("signed", relu8(8'sd127), relu8(8'sd0));

      // Back-pressure: out_ready low, in_valid held high
      sm_pix = '{8'sd1, 8'sd5, 8'sd2, 8'sd3, 8'sd4, 8'sd0, 8'sd7, 8'sd6};
      sent = 0; s_fd = 0; s_got.delete();
      s_en = 1'b1; s_ordy = 1'b0;
      bcyc = 0;
      while (!s_out_valid && bcyc < 20) begin
         small_cycle();
         bcyc++;
      end
      check("stall_latency_sent", sent, 6);
      check("stall_first_data", s_out_data, relu8(8'sd5));
      check("stall_in_ready_low", s_in_ready, 0);
      repeat (4) small_cycle();
      check("stall_sent_frozen", sent, 6);
      check("stall_out_valid_held", s_out_valid, 1);
      check("stall_data_held", s_out_data, relu8(8'sd5));
      check("stall_nothing_taken", s_got.size(), 0);
      s_ordy = 1'b1;
      repeat (8) small_cycle();
      s_en = 1'b0;
      check("resume_sent", sent, 8);
      check("resume_count", s_got.size(), 2);
      check("resume_out0", s_got[0], relu8(8'sd5));
      check("resume_out1", s_got[1], relu8(8'sd7));
      check("resume_frame_done", s_fd, 1);

      // Reset mid-frame with a pending output, then a fresh frame
      sm_pix = '{8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9, 8'sd9};
      sent = 0; s_got.delete();
      s_en = 1'b1; s_ordy = 1'b0;
      repeat (7) small_cycle();
      check("midrst_pending_before", s_out_valid, 1);
      check("midrst_sent_before", sent, 6);
      @(posedge clk);
      #1;
      RSTn = 1'b0;
      s_in_valid = 1'b0; s_en = 1'b0;
      #1;
      check("midrst_out_valid", s_out_valid, 0);
      check("midrst_in_ready", s_in_ready, 1);
      check("midrst_frame_done", s_frame_done, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("midrst_out_valid_held", s_out_valid, 0);
      RSTn = 1'b1;
      sm_pix = '{8'sd1, 8'sd5, 8'sd2, 8'sd3, 8'sd4, 8'sd0, 8'sd7, 8'sd6};
      run_small("after_rst", relu8(8'sd5), relu8(8'sd7));

      // Two back-to-back 28x28 random frames against a 4-way max model
      for (int i = 0; i < 1568; i++) pix_b[i] = 8'($urandom);
      for (int f = 0; f < 2; f++)
         for (int r = 0; r < 14; r++)
            for (int c = 0; c < 14; c++) begin
               int base;
               logic signed [7:0] m;
               base = f * 784 + 2 * r * 28 + 2 * c;
               m = pix_b[base];
               if (pix_b[base + 1]  > m) m = pix_b[base + 1];
               if (pix_b[base + 28] > m) m = pix_b[base + 28];
               if (pix_b[base + 29] > m) m = pix_b[base + 29];
               exp_b[f * 196 + r * 14 + c] = relu8(m);
            end
      bsent = 0; bgot = 0; bfd = 0; bcyc = 0;
      while (!(bgot == 392 && bfd == 2) && bcyc < 20000) begin
         @(posedge clk);
         #1;
         b_in_valid  = (bsent < 1568) && ($urandom_range(1, 0) == 1);
         b_in_data   = b_in_valid ? pix_b[bsent] : 8'sd0;
         b_out_ready = ($urandom_range(3, 0) != 0);
         @(negedge clk);
         if (b_in_valid && b_in_ready) bsent++;
         if (b_out_valid && b_out_ready) begin
            if (bgot < 392) check("big_out", b_out_data, exp_b[bgot]);
            bgot++;
         end
         if (b_frame_done) begin
            bfd++;
            check("big_frame_done_pos", bgot, 196 * bfd);
         end
         bcyc++;
      end
      b_in_valid = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (b_out_valid && b_out_ready) bgot++;
         if (b_frame_done) bfd++;
      end
      check("big_sent", bsent, 1568);
      check("big_results", bgot, 392);
      check("big_frame_done_count", bfd, 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
